decode_stage_pipe: RTL and testbench
====================================

// Module: decode_stage_pipe
// PURPOSE
//  Parametrised decode stage: IF/ID register, register file with write-back port, sign/zero immediate
//  extension, operand-B select, load-use hazard stall, flush, and ID/EX register with valid bit.
//  Sits between fetch and execute; opcode goes out to the external control unit, decoded control returns.
//  Generalises the fixed 16-bit fetch/decode/execute chain with valid, stall, flush and bypass.
// PARAMETERS
//  DATA_W    16  register/operand width
//  INSTR_W   16  instruction width; fields opcode[15:12] rd[11:8] rs2[7:4] rs1[3:0] are fixed
//  NUM_REGS  16  register count, 2..16; address = low $clog2(NUM_REGS) bits of each field
//  CTRL_W    8   width of opaque control bundle passed to execute (wbs,wme,mm,ALUop,wm,am,ni)
//  SIMM_W    8   sign-extended immediate field instr[SIMM_W-1:0]
//  ZIMM_W    13  zero-extended immediate field instr[ZIMM_W-1:0]
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous reset, active low
//  if_valid    in   1        if_instr holds a real instruction
//  if_instr    in   INSTR_W  instruction from fetch
//  if_stall    out  1        fetch must hold PC and if_instr this cycle (combinational)
//  flush       in   1        kill instructions in IF/ID and ID/EX (taken branch)
//  id_opcode   out  4        IF/ID instr[15:12] to control unit
//  ctrl_ri     in   2        operand-B select: 0 rd2, 1 rd3, 2 sext imm, 3 zext imm
//  ctrl_wre    in   1        instruction writes rd
//  ctrl_load   in   1        rd written from memory (load)
//  ctrl_use2   in   1        instruction reads rs2 (register operand B)
//  ctrl_bundle in   CTRL_W   remaining decoded control
//  wb_en       in   1        write-back enable
//  wb_addr     in   4        write-back register
//  wb_data     in   DATA_W   write-back value
//  ex_valid    out  1        ID/EX holds a real instruction
//  ex_ctrl     out  CTRL_W   registered ctrl_bundle
//  ex_wre      out  1        registered ctrl_wre
//  ex_load     out  1        registered ctrl_load
//  ex_rd       out  4        registered rd field
//  ex_srcA     out  DATA_W   registered rd1 (rs1)
//  ex_srcB     out  DATA_W   registered operand-B mux result
//  ex_store    out  DATA_W   registered rd3 (store data)
// BEHAVIOUR
//  - Reset (async, rst_n=0): id_valid, id_instr, all ex_* outputs and all registers = 0; if_stall=0.
//  - Latency: instruction accepted into IF/ID at edge N reaches ex_* at edge N+1 (no stall).
//  - Regfile: write on rising edge when wb_en; reads combinational; 3 read ports rs1, rs2, rd.
//  - sext = {{DATA_W-SIMM_W{instr[SIMM_W-1]}},instr[SIMM_W-1:0]}; zext zero-pads; DATA_W < field truncates upper bits.
//  - Hazard: haz = id_valid & ex_valid & ex_load & ex_wre & (ex_rd==rs1 | (ctrl_use2 & ex_rd==rs2) | (ctrl_ri==1 & ex_rd==rd)).
//  - if_stall = haz & ~flush.
//  - Stall: IF/ID holds; ID/EX loads bubble (ex_valid=0, ex_wre=0, ex_load=0, ex_ctrl=0, data regs hold).
//  - Exactly one bubble per load-use: next cycle ex_load=0, so haz clears.
//  - Flush: priority over stall; IF/ID <= valid 0; ID/EX <= bubble; if_stall=0.
//  - Normal edge: IF/ID <= {if_valid,if_instr}; ID/EX <= decoded values gated by id_valid.
//  - Invalid IF/ID produces bubble in ID/EX.
//  - Controls into ID/EX with id_valid=0 are forced 0, so ctrl_* are don't-care then.
//  - Reset mid-operation: all state cleared immediately; first edge after release accepts if_instr.
// CONFIGURATION
//  WB_BYPASS_EN defined: read address == wb_addr with wb_en returns wb_data same cycle (write-first).
//    Applies to all 3 ports.
//  WB_BYPASS_EN undefined: reads return the stored value; the new value is visible the cycle after the write edge.
// TESTING
//  1. Reset asserted mid-run with ex_valid=1 -> all ex_* = 0, if_stall=0 immediately, before any clock.
//  2. mov r8,#7 (0x8807, ri=2): two edges -> ex_valid=1, ex_rd=8, ex_srcB=0x0007; 0x80F9 gives ex_srcB=0xFFF9.
//  3. Load to r8 in EX, next instr sub r2,r8,r1 (0x0281) -> if_stall=1 one cycle, ex_valid=0.
//     Then sub reaches EX with ex_rd=2.
//  4. flush=1 while stall active -> if_stall=0; after edge IF/ID and ID/EX invalid.
//  5. wb_en=1 wb_addr=1 wb_data=0x000F with IF/ID reading rs1=1.
//     With WB_BYPASS_EN: ex_srcA=0x000F next edge. Without: old value.
//  6. ri=3 with instr 0x9FFF -> ex_srcB=0x1FFF; ri=1 -> ex_srcB=ex_store=reg[rd].

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Decode stage: IF/ID register, 3-read/1-write register file, immediate extension,
// operand-B select, load-use stall, flush and ID/EX register. Optional macro WB_BYPASS_EN.
module decode_stage_pipe #(
  parameter int DATA_W   = 16,
  parameter int INSTR_W  = 16,
  parameter int NUM_REGS = 16,
  parameter int CTRL_W   = 8,
  parameter int SIMM_W   = 8,
  parameter int ZIMM_W   = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  output logic              if_stall,
  input  logic              flush,
  output logic [3:0]        id_opcode,
  input  logic [1:0]        ctrl_ri,
  input  logic              ctrl_wre,
  input  logic              ctrl_load,
  input  logic              ctrl_use2,
  input  logic [CTRL_W-1:0] ctrl_bundle,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_wre,
  output logic              ex_load,
  output logic [3:0]        ex_rd,
  output logic [DATA_W-1:0] ex_srcA,
  output logic [DATA_W-1:0] ex_srcB,
  output logic [DATA_W-1:0] ex_store
);

  localparam int AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int DEPTH = 2 ** AW;

  logic               r_idValid;
  logic [INSTR_W-1:0] r_idInstr;
  logic [DATA_W-1:0]  r_regs [DEPTH];

  logic               r_exValid;
  logic [CTRL_W-1:0]  r_exCtrl;
  logic               r_exWre;
  logic               r_exLoad;
  logic [3:0]         r_exRd;
  logic [DATA_W-1:0]  r_exSrcA;
  logic [DATA_W-1:0]  r_exSrcB;
  logic [DATA_W-1:0]  r_exStore;

  logic [AW-1:0]             w_rdAddr [3];
  logic [DATA_W-1:0]         w_rdData [3];
  logic [AW-1:0]             w_wbAddr;
  logic [AW-1:0]             w_exRdAddr;
  logic signed [SIMM_W-1:0]  w_simmField;
  logic [ZIMM_W-1:0]         w_zimmField;
  logic [DATA_W-1:0]         w_sext;
  logic [DATA_W-1:0]         w_zext;
  logic [DATA_W-1:0]         w_opB;
  logic                      w_haz;
  logic                      w_bubble;

  // Read ports: 0 = rs1, 1 = rs2, 2 = rd (store data / register operand B)
  assign w_rdAddr[0] = r_idInstr[0 +: AW];
  assign w_rdAddr[1] = r_idInstr[4 +: AW];
  assign w_rdAddr[2] = r_idInstr[8 +: AW];
  assign w_wbAddr    = wb_addr[AW-1:0];
  assign w_exRdAddr  = r_exRd[AW-1:0];
  assign id_opcode   = r_idInstr[15:12];

  // Entries at or above NUM_REGS are never written and read back as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (wb_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wbAddr == AW'(i)) r_regs[i] <= wb_data;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      w_rdData[p] = r_regs[w_rdAddr[p]];
`ifdef WB_BYPASS_EN
      if (wb_en && (w_wbAddr == w_rdAddr[p]) && (int'(w_wbAddr) < NUM_REGS))
        w_rdData[p] = wb_data;
`endif
    end
  end

  // Size casts sign-extend / zero-pad, or truncate when DATA_W is narrower than the field
  assign w_simmField = r_idInstr[SIMM_W-1:0];
  assign w_zimmField = r_idInstr[ZIMM_W-1:0];
  assign w_sext      = DATA_W'(w_simmField);
  assign w_zext      = DATA_W'(w_zimmField);

  always_comb begin
    w_opB = w_rdData[1];
    unique case (ctrl_ri)
      2'd0:    w_opB = w_rdData[1];
      2'd1:    w_opB = w_rdData[2];
      2'd2:    w_opB = w_sext;
      2'd3:    w_opB = w_zext;
      default: w_opB = w_rdData[1];
    endcase
  end

  assign w_haz = r_idValid & r_exValid & r_exLoad & r_exWre &
                 ((w_exRdAddr == w_rdAddr[0]) |
                  (ctrl_use2 & (w_exRdAddr == w_rdAddr[1])) |
                  ((ctrl_ri == 2'd1) & (w_exRdAddr == w_rdAddr[2])));

  assign if_stall = w_haz & ~flush;
  assign w_bubble = flush | w_haz | ~r_idValid;

  // Flush wins over stall; a stalled IF/ID simply keeps its contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idValid <= 1'b0;
      r_idInstr <= '0;
    end else if (flush) begin
      r_idValid <= 1'b0;
    end else if (!w_haz) begin
      r_idValid <= if_valid;
      r_idInstr <= if_instr;
    end
  end

  // Bubbles clear only the control half of ID/EX; data registers keep their old values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exValid <= 1'b0;
      r_exCtrl  <= '0;
      r_exWre   <= 1'b0;
      r_exLoad  <= 1'b0;
      r_exRd    <= '0;
      r_exSrcA  <= '0;
      r_exSrcB  <= '0;
      r_exStore <= '0;
    end else if (w_bubble) begin
      r_exValid <= 1'b0;
      r_exCtrl  <= '0;
      r_exWre   <= 1'b0;
      r_exLoad  <= 1'b0;
    end else begin
      r_exValid <= 1'b1;
      r_exCtrl  <= ctrl_bundle;
      r_exWre   <= ctrl_wre;
      r_exLoad  <= ctrl_load;
      r_exRd    <= r_idInstr[11:8];
      r_exSrcA  <= w_rdData[0];
      r_exSrcB  <= w_opB;
      r_exStore <= w_rdData[2];
    end
  end

  assign ex_valid = r_exValid;
  assign ex_ctrl  = r_exCtrl;
  assign ex_wre   = r_exWre;
  assign ex_load  = r_exLoad;
  assign ex_rd    = r_exRd;
  assign ex_srcA  = r_exSrcA;
  assign ex_srcB  = r_exSrcB;
  assign ex_store = r_exStore;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe; expected values are hand-computed.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = '0;
  logic        if_stall;
  logic        flush = 1'b0;
  logic [3:0]  id_opcode;
  logic [1:0]  ctrl_ri = '0;
  logic        ctrl_wre = 1'b0;
  logic        ctrl_load = 1'b0;
  logic        ctrl_use2 = 1'b0;
  logic [7:0]  ctrl_bundle = '0;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        ex_valid;
  logic [7:0]  ex_ctrl;
  logic        ex_wre;
  logic        ex_load;
  logic [3:0]  ex_rd;
  logic [15:0] ex_srcA;
  logic [15:0] ex_srcB;
  logic [15:0] ex_store;

  int compared = 0;
  int mismatched = 0;

  decode_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_stall(if_stall),
    .flush(flush), .id_opcode(id_opcode), .ctrl_ri(ctrl_ri), .ctrl_wre(ctrl_wre),
    .ctrl_load(ctrl_load), .ctrl_use2(ctrl_use2), .ctrl_bundle(ctrl_bundle),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_wre(ex_wre), .ex_load(ex_load), .ex_rd(ex_rd),
    .ex_srcA(ex_srcA), .ex_srcB(ex_srcB), .ex_store(ex_store)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic [1:0] ri,
                               input logic wre, input logic load, input logic use2,
                               input logic [7:0] bundle);
    if_valid    = v;
    if_instr    = instr;
    ctrl_ri     = ri;
    ctrl_wre    = wre;
    ctrl_load   = load;
    ctrl_use2   = use2;
    ctrl_bundle = bundle;
  endtask

  task automatic test_reset();
    #12;
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ex_valid: got %b expected 0", ex_valid); end
    compared++; if (if_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_if_stall: got %b expected 0", if_stall); end
    compared++; if (id_opcode !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_id_opcode: got %h expected 0", id_opcode); end
    compared++; if (ex_srcA !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_ex_srcA: got %h expected 0000", ex_srcA); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mov();
    applyStimulus(1'b1, 16'h8807, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    compared++; if (id_opcode !== 4'h8) begin mismatched++; $display("[TB] FAIL mov_id_opcode: got %h expected 8", id_opcode); end
    applyStimulus(1'b1, 16'h80F9, 2'd2, 1'b1, 1'b0, 1'b0, 8'hA5);
    tick();
    compared++; if (ex_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mov_ex_valid: got %b expected 1", ex_valid); end
    compared++; if (ex_rd !== 4'h8) begin mismatched++; $display("[TB] FAIL mov_ex_rd: got %h expected 8", ex_rd); end
    compared++; if (ex_srcB !== 16'h0007) begin mismatched++; $display("[TB] FAIL mov_srcB_pos: got %h expected 0007", ex_srcB); end
    compared++; if (ex_ctrl !== 8'hA5) begin mismatched++; $display("[TB] FAIL mov_ex_ctrl: got %h expected a5", ex_ctrl); end
    compared++; if (ex_wre !== 1'b1) begin mismatched++; $display("[TB] FAIL mov_ex_wre: got %b expected 1", ex_wre); end
    applyStimulus(1'b0, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b0, 8'hA5);
    tick();
    compared++; if (ex_srcB !== 16'hFFF9) begin mismatched++; $display("[TB] FAIL mov_srcB_neg: got %h expected fff9", ex_srcB); end
    tick();
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL invalid_bubble_valid: got %b expected 0", ex_valid); end
    compared++; if (ex_wre !== 1'b0) begin mismatched++; $display("[TB] FAIL invalid_bubble_wre: got %b expected 0", ex_wre); end
    compared++; if (ex_ctrl !== 8'h00) begin mismatched++; $display("[TB] FAIL invalid_bubble_ctrl: got %h expected 00", ex_ctrl); end
  endtask

  task automatic test_load_use();
    applyStimulus(1'b1, 16'hA800, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 16'h0281, 2'd0, 1'b1, 1'b1, 1'b0, 8'h11);
    tick();
    compared++; if (ex_load !== 1'b1) begin mismatched++; $display("[TB] FAIL lu_ex_load: got %b expected 1", ex_load); end
    applyStimulus(1'b1, 16'h0281, 2'd0, 1'b1, 1'b0, 1'b1, 8'h22);
    #1;
    compared++; if (if_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL lu_stall_on: got %b expected 1", if_stall); end
    tick();
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_bubble_valid: got %b expected 0", ex_valid); end
    compared++; if (ex_load !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_bubble_load: got %b expected 0", ex_load); end
    compared++; if (ex_rd !== 4'h8) begin mismatched++; $display("[TB] FAIL lu_bubble_rd_hold: got %h expected 8", ex_rd); end
    compared++; if (if_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL lu_stall_off: got %b expected 0", if_stall); end
    tick();
    compared++; if (ex_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL lu_sub_valid: got %b expected 1", ex_valid); end
    compared++; if (ex_rd !== 4'h2) begin mismatched++; $display("[TB] FAIL lu_sub_rd: got %h expected 2", ex_rd); end
    compared++; if (ex_ctrl !== 8'h22) begin mismatched++; $display("[TB] FAIL lu_sub_ctrl: got %h expected 22", ex_ctrl); end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, 16'hA800, 2'd0, 1'b1, 1'b0, 1'b1, 8'h22);
    tick();
    applyStimulus(1'b1, 16'h0281, 2'd0, 1'b1, 1'b1, 1'b0, 8'h11);
    tick();
    applyStimulus(1'b1, 16'h0281, 2'd0, 1'b1, 1'b0, 1'b1, 8'h22);
    #1;
    compared++; if (if_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL fl_stall_before: got %b expected 1", if_stall); end
    flush = 1'b1;
    #1;
    compared++; if (if_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_stall_killed: got %b expected 0", if_stall); end
    tick();
    flush = 1'b0;
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_ex_valid: got %b expected 0", ex_valid); end
    compared++; if (ex_load !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_ex_load: got %b expected 0", ex_load); end
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'h33);
    tick();
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_idif_invalid: got %b expected 0", ex_valid); end
    compared++; if (ex_wre !== 1'b0) begin mismatched++; $display("[TB] FAIL fl_idif_wre: got %b expected 0", ex_wre); end
  endtask

  task automatic test_writeback();
    logic [15:0] expectA;
    wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'h1234;
    tick();
    wb_en = 1'b0;
    applyStimulus(1'b1, 16'h0301, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'h000F;
`ifdef WB_BYPASS_EN
    expectA = 16'h000F;
`else
    expectA = 16'h1234;
`endif
    tick();
    wb_en = 1'b0;
    compared++; if (ex_srcA !== expectA) begin mismatched++; $display("[TB] FAIL wb_same_cycle: got %h expected %h", ex_srcA, expectA); end
    applyStimulus(1'b1, 16'h0301, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    compared++; if (ex_srcA !== 16'h000F) begin mismatched++; $display("[TB] FAIL wb_next_cycle: got %h expected 000f", ex_srcA); end
  endtask

  task automatic test_imm();
    applyStimulus(1'b1, 16'h9FFF, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 16'h9100, 2'd3, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    compared++; if (ex_srcB !== 16'h1FFF) begin mismatched++; $display("[TB] FAIL imm_zext: got %h expected 1fff", ex_srcB); end
    compared++; if (ex_rd !== 4'hF) begin mismatched++; $display("[TB] FAIL imm_rd: got %h expected f", ex_rd); end
    applyStimulus(1'b1, 16'h0010, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    compared++; if (ex_srcB !== 16'h000F) begin mismatched++; $display("[TB] FAIL imm_ri1_srcB: got %h expected 000f", ex_srcB); end
    compared++; if (ex_store !== 16'h000F) begin mismatched++; $display("[TB] FAIL imm_ri1_store: got %h expected 000f", ex_store); end
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    compared++; if (ex_srcB !== 16'h000F) begin mismatched++; $display("[TB] FAIL imm_ri0_srcB: got %h expected 000f", ex_srcB); end
    compared++; if (ex_store !== 16'h0000) begin mismatched++; $display("[TB] FAIL imm_ri0_store: got %h expected 0000", ex_store); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 16'hA800, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 16'h0281, 2'd0, 1'b1, 1'b1, 1'b0, 8'h44);
    tick();
    applyStimulus(1'b1, 16'h0281, 2'd0, 1'b1, 1'b0, 1'b1, 8'h55);
    #1;
    compared++; if (ex_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rm_pre_valid: got %b expected 1", ex_valid); end
    compared++; if (if_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL rm_pre_stall: got %b expected 1", if_stall); end
    rst_n = 1'b0;
    #1;
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_ex_valid: got %b expected 0", ex_valid); end
    compared++; if (if_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_if_stall: got %b expected 0", if_stall); end
    compared++; if (ex_load !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_ex_load: got %b expected 0", ex_load); end
    compared++; if (ex_ctrl !== 8'h00) begin mismatched++; $display("[TB] FAIL rm_ex_ctrl: got %h expected 00", ex_ctrl); end
    compared++; if (ex_rd !== 4'h0) begin mismatched++; $display("[TB] FAIL rm_ex_rd: got %h expected 0", ex_rd); end
    compared++; if (ex_srcB !== 16'h0000) begin mismatched++; $display("[TB] FAIL rm_ex_srcB: got %h expected 0000", ex_srcB); end
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h3301, 2'd0, 1'b1, 1'b0, 1'b0, 8'h66);
    tick();
    compared++; if (id_opcode !== 4'h3) begin mismatched++; $display("[TB] FAIL rm_first_accept: got %h expected 3", id_opcode); end
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 8'h66);
    tick();
    compared++; if (ex_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rm_after_valid: got %b expected 1", ex_valid); end
    compared++; if (ex_rd !== 4'h3) begin mismatched++; $display("[TB] FAIL rm_after_rd: got %h expected 3", ex_rd); end
    compared++; if (ex_srcA !== 16'h0000) begin mismatched++; $display("[TB] FAIL rm_regs_cleared: got %h expected 0000", ex_srcA); end
  endtask

  initial begin
    test_reset();
    test_mov();
    test_load_use();
    test_flush();
    test_writeback();
    test_imm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
